pd_axis_sched: RTL and testbench
================================

PD_AXIS_SCHED -- requirements
Module: pd_axis_sched

Interface
REQ-001 Parameter D_QUEUE_DEPTH, default 12, SHALL set derivative history depth in samples per axis.
REQ-002 Parameter DTERM, default 5'b00111, SHALL set the signed derivative gain.
REQ-003 clk  input  1  SHALL be the single clock; all state rises on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 vld  input  1  SHALL be the new-inertial-sample strobe, one cycle wide.
REQ-006 ptch, roll, yaw  input  16 each  SHALL be signed actual attitudes.
REQ-007 d_ptch, d_roll, d_yaw  input  16 each  SHALL be signed desired attitudes.
REQ-008 ptch_pterm, roll_pterm, yaw_pterm  output  10 each  SHALL be registered signed P terms.
REQ-009 ptch_dterm, roll_dterm, yaw_dterm  output  12 each  SHALL be registered signed D terms.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-011 done  output  1  SHALL be a one-cycle pulse when all three axes are updated.
REQ-012 ovr  output  1  SHALL be a sticky flag for vld received while busy.

Function
REQ-013 One shared PD datapath SHALL serve all three axes, time-multiplexed.
REQ-014 FSM states SHALL be IDLE, PTCH, ROLL, YAW, COMMIT; IDLE->PTCH on vld, PTCH->ROLL->YAW->COMMIT->IDLE unconditionally.
REQ-015 On vld in IDLE, all six attitude inputs SHALL be snapshotted; later input changes SHALL NOT affect the current sequence.
REQ-016 err SHALL be the 17-bit difference actual-desired, saturated to signed 10 bits [-512,511].
REQ-017 D_diff SHALL be err_sat minus that axis's oldest history entry, 10-bit, saturated to signed 7 bits [-64,63].
REQ-018 dterm SHALL be D_diff_sat times DTERM, signed, 12 bits.
REQ-019 pterm SHALL be (err_sat>>>1)+(err_sat>>>3), arithmetic shifts, 10 bits.
REQ-020 Each axis state SHALL register that axis's pterm/dterm and overwrite its oldest history entry with err_sat.
REQ-021 History SHALL be a per-axis circular buffer sharing one write pointer, 0..D_QUEUE_DEPTH-1, wrapping to 0; the pointer advances only in COMMIT.
REQ-022 done SHALL assert in COMMIT, i.e. the 4th cycle after the vld-sampling edge.
REQ-023 vld while busy SHALL be ignored, SHALL set ovr, and SHALL NOT disturb the sequence; vld in COMMIT is also ignored.
REQ-024 ovr SHALL clear only on reset.

Reset
REQ-025 Reset SHALL force IDLE, all terms 0, history all 0, pointer 0, busy/done/ovr 0, at any time including mid-sequence.
REQ-026 An aborted sequence SHALL leave no partial history write or pointer advance visible after reset.

Configuration
REQ-027 Macro PD_OVR_CNT_EN defined: add output ovr_cnt[7:0], saturating at 255, incremented per ignored vld, reset to 0.
REQ-028 Macro undefined: no ovr_cnt port or logic; ovr flag only.

Structure
REQ-029 Package pd_sched_pkg SHALL hold the state enum, the D_QUEUE_DEPTH and DTERM defaults, and the axis-index typedef.
REQ-030 Combinational math SHALL be sub-module pd_core (err/D_diff saturation, pterm, dterm), with no history storage.

Verification
REQ-031 Reset then idle: all terms 0, busy 0, done 0, ovr 0.
REQ-032 ptch=100, d_ptch=0, one vld: ptch_pterm=62, ptch_dterm=441; done four cycles later.
REQ-033 roll=16'h7FFF, d_roll=16'h8000: roll_pterm=318, roll_dterm=441; yaw=-1000, d_yaw=0: yaw_pterm=-320, yaw_dterm=-448.
REQ-034 Thirteen vlds with constant ptch err 100: vlds 1-12 give dterm=441; vld 13 gives dterm=0, pterm=62 (pointer wrap).
REQ-035 vld pulsed during ROLL: ovr=1, done still once, outputs match single-vld case; with PD_OVR_CNT_EN, ovr_cnt=1.
REQ-036 rst_n asserted in YAW, then released and one vld with err 100: dterm=441, proving history cleared.

Source files
------------

// File: rtl/pd_axis_sched_pkg.sv
// Shared types and default parameters for the time-multiplexed PD attitude scheduler.
// Saturation helpers live here so the datapath stays readable.
package pd_sched_pkg;

  localparam int                D_QUEUE_DEPTH_DEF = 12;
  localparam logic signed [4:0] DTERM_DEF         = 5'sb00111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PTCH   = 3'd1,
    ST_ROLL   = 3'd2,
    ST_YAW    = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    AX_PTCH = 2'd0,
    AX_ROLL = 2'd1,
    AX_YAW  = 2'd2
  } axis_e;

  function automatic logic signed [9:0] sat_err(input logic signed [16:0] v);
    if (v > 17'sd511)       return 10'sd511;
    else if (v < -17'sd512) return -10'sd512;
    else                    return v[9:0];
  endfunction

  function automatic logic signed [6:0] sat_diff(input logic signed [10:0] v);
    if (v > 11'sd63)       return 7'sd63;
    else if (v < -11'sd64) return -7'sd64;
    else                   return v[6:0];
  endfunction

endpackage

// File: rtl/pd_axis_sched_if.sv
// Sample/term bus between the inertial front end and the PD scheduler.
// ovr_cnt exists only when PD_OVR_CNT_EN is defined.
interface pd_axis_sched_if;
  logic               vld;
  logic signed [15:0] ptch, roll, yaw;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic signed [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
  logic signed [11:0] ptch_dterm, roll_dterm, yaw_dterm;
  logic               busy;
  logic               done;
  logic               ovr;
`ifdef PD_OVR_CNT_EN
  logic [7:0]         ovr_cnt;
`endif

  modport master (
    output vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
    input  ptch_pterm, roll_pterm, yaw_pterm,
    input  ptch_dterm, roll_dterm, yaw_dterm,
    input  busy, done, ovr
`ifdef PD_OVR_CNT_EN
    , input ovr_cnt
`endif
  );

  modport slave (
    input  vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
    output ptch_pterm, roll_pterm, yaw_pterm,
    output ptch_dterm, roll_dterm, yaw_dterm,
    output busy, done, ovr
`ifdef PD_OVR_CNT_EN
    , output ovr_cnt
`endif
  );
endinterface

// File: rtl/pd_axis_sched_core.sv
// Combinational PD math for one axis: error/derivative saturation, P and D terms.
// Holds no state; the scheduler feeds it the snapshot and the oldest history entry.
module pd_core
  import pd_sched_pkg::*;
#(
  parameter logic signed [4:0] DTERM = DTERM_DEF
) (
  input  logic signed [15:0] act,
  input  logic signed [15:0] des,
  input  logic signed [9:0]  hist_old,
  output logic signed [9:0]  err_sat,
  output logic signed [9:0]  pterm,
  output logic signed [11:0] dterm
);

  logic signed [16:0] err_raw;
  logic signed [10:0] d_raw;
  logic signed [6:0]  d_sat;

  always_comb begin
    err_raw = $signed({act[15], act}) - $signed({des[15], des});
    err_sat = sat_err(err_raw);
    // one extra bit so full-scale swings saturate instead of wrapping
    d_raw   = $signed({err_sat[9], err_sat}) - $signed({hist_old[9], hist_old});
    d_sat   = sat_diff(d_raw);
    pterm   = (err_sat >>> 1) + (err_sat >>> 3);
    dterm   = $signed({{5{d_sat[6]}}, d_sat}) * $signed({{7{DTERM[4]}}, DTERM});
  end

endmodule

// File: rtl/pd_axis_sched.sv
// Three-axis PD scheduler: one shared pd_core walks ptch, roll, yaw per sample.
// Optional PD_OVR_CNT_EN adds a saturating count of ignored samples.
//
// state  | meaning
// IDLE   | waiting for vld; snapshots attitudes when it arrives
// PTCH   | pitch terms registered, pitch history written
// ROLL   | roll terms registered, roll history written
// YAW    | yaw terms registered, yaw history written
// COMMIT | done pulse, shared history pointer advances
module pd_axis_sched
  import pd_sched_pkg::*;
#(
  parameter int                D_QUEUE_DEPTH = D_QUEUE_DEPTH_DEF,
  parameter logic signed [4:0] DTERM         = DTERM_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  pd_axis_sched_if.slave bus
);

  localparam int PTR_W = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;

  state_e             state_q, state_d;
  logic signed [15:0] snap_act_q [3];
  logic signed [15:0] snap_act_d [3];
  logic signed [15:0] snap_des_q [3];
  logic signed [15:0] snap_des_d [3];
  logic signed [9:0]  hist_q [3][D_QUEUE_DEPTH];
  logic signed [9:0]  hist_d [3][D_QUEUE_DEPTH];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic signed [9:0]  pterm_q [3];
  logic signed [9:0]  pterm_d [3];
  logic signed [11:0] dterm_q [3];
  logic signed [11:0] dterm_d [3];
  logic               ovr_q, ovr_d;

  logic               busy, done, axis_act, vld_ignored;
  axis_e              axis;
  logic signed [9:0]  core_err, core_p;
  logic signed [11:0] core_d;

  pd_core #(.DTERM(DTERM)) u_core (
    .act      (snap_act_q[axis]),
    .des      (snap_des_q[axis]),
    .hist_old (hist_q[axis][ptr_q]),
    .err_sat  (core_err),
    .pterm    (core_p),
    .dterm    (core_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.vld) state_d = ST_PTCH;
      ST_PTCH:   state_d = ST_ROLL;
      ST_ROLL:   state_d = ST_YAW;
      ST_YAW:    state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_COMMIT);
    axis_act = 1'b1;
    axis     = AX_PTCH;
    unique case (state_q)
      ST_PTCH: axis = AX_PTCH;
      ST_ROLL: axis = AX_ROLL;
      ST_YAW:  axis = AX_YAW;
      default: axis_act = 1'b0;
    endcase
  end

  assign vld_ignored = bus.vld && busy;

  always_comb begin
    snap_act_d = snap_act_q;
    snap_des_d = snap_des_q;
    hist_d     = hist_q;
    ptr_d      = ptr_q;
    pterm_d    = pterm_q;
    dterm_d    = dterm_q;
    ovr_d      = ovr_q | vld_ignored;
    if ((state_q == ST_IDLE) && bus.vld) begin
      snap_act_d[0] = bus.ptch;
      snap_act_d[1] = bus.roll;
      snap_act_d[2] = bus.yaw;
      snap_des_d[0] = bus.d_ptch;
      snap_des_d[1] = bus.d_roll;
      snap_des_d[2] = bus.d_yaw;
    end
    if (axis_act) begin
      hist_d[axis][ptr_q] = core_err;
      pterm_d[axis]       = core_p;
      dterm_d[axis]       = core_d;
    end
    if (state_q == ST_COMMIT)
      ptr_d = (ptr_q == PTR_W'(D_QUEUE_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 3; a++) begin
        snap_act_q[a] <= '0;
        snap_des_q[a] <= '0;
        pterm_q[a]    <= '0;
        dterm_q[a]    <= '0;
        for (int i = 0; i < D_QUEUE_DEPTH; i++) hist_q[a][i] <= '0;
      end
      ptr_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      snap_act_q <= snap_act_d;
      snap_des_q <= snap_des_d;
      hist_q     <= hist_d;
      ptr_q      <= ptr_d;
      pterm_q    <= pterm_d;
      dterm_q    <= dterm_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef PD_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (vld_ignored && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_cnt_q <= '0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign bus.ovr_cnt = ovr_cnt_q;
`endif

  assign bus.ptch_pterm = pterm_q[0];
  assign bus.roll_pterm = pterm_q[1];
  assign bus.yaw_pterm  = pterm_q[2];
  assign bus.ptch_dterm = dterm_q[0];
  assign bus.roll_dterm = dterm_q[1];
  assign bus.yaw_dterm  = dterm_q[2];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_pd_axis_sched.sv
// Self-checking bench for pd_axis_sched: directed spec cases plus randomized samples
// against a queue-based model of "error from DEPTH samples ago".
module tb_pd_axis_sched;
  import pd_sched_pkg::*;

  localparam int DEPTH = 12;
  localparam int GAIN  = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pd_axis_sched_if bus ();

  pd_axis_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int eq[$];
  int exp_p[3];
  int exp_d[3];
  int act_v[3];
  int des_v[3];

  function automatic int sat(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model_reset();
    eq.delete();
  endfunction

  // history is just the list of past errors; the oldest entry is DEPTH samples back
  function automatic void model_step();
    int es[3];
    int old;
    for (int a = 0; a < 3; a++) begin
      es[a]    = sat(act_v[a] - des_v[a], -512, 511);
      old      = (eq.size() == 3 * DEPTH) ? eq[a] : 0;
      exp_p[a] = (es[a] >>> 1) + (es[a] >>> 3);
      exp_d[a] = sat(es[a] - old, -64, 63) * GAIN;
    end
    for (int a = 0; a < 3; a++) eq.push_back(es[a]);
    if (eq.size() > 3 * DEPTH) repeat (3) void'(eq.pop_front());
  endfunction

  function automatic int got_p(int a);
    case (a)
      0:       return int'(bus.ptch_pterm);
      1:       return int'(bus.roll_pterm);
      default: return int'(bus.yaw_pterm);
    endcase
  endfunction

  function automatic int got_d(int a);
    case (a)
      0:       return int'(bus.ptch_dterm);
      1:       return int'(bus.roll_dterm);
      default: return int'(bus.yaw_dterm);
    endcase
  endfunction

  task automatic drive_inputs();
    bus.ptch   = 16'(act_v[0]);
    bus.roll   = 16'(act_v[1]);
    bus.yaw    = 16'(act_v[2]);
    bus.d_ptch = 16'(des_v[0]);
    bus.d_roll = 16'(des_v[1]);
    bus.d_yaw  = 16'(des_v[2]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // lat = negedges from the vld edge to done (-1 on timeout); done_after = done one cycle later
  task automatic send_sample(output int lat, output int done_after);
    @(negedge clk);
    drive_inputs();
    bus.vld = 1'b1;
    model_step();
    @(negedge clk);
    bus.vld = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    @(negedge clk);
    done_after = int'(bus.done);
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_tests++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", bus.ovr); end
    for (int a = 0; a < 3; a++) begin
      n_tests++; if (got_p(a) !== 0) begin n_fail++; $display("FAIL reset_pterm[%0d]: got %0d expected 0", a, got_p(a)); end
      n_tests++; if (got_d(a) !== 0) begin n_fail++; $display("FAIL reset_dterm[%0d]: got %0d expected 0", a, got_d(a)); end
    end
`ifdef PD_OVR_CNT_EN
    n_tests++; if (bus.ovr_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovr_cnt: got %0d expected 0", bus.ovr_cnt); end
`endif
  endtask

  task automatic test_directed();
    int lat, da;
    act_v = '{100, 0, 0};
    des_v = '{0, 0, 0};
    send_sample(lat, da);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL dir_latency: got %0d expected 4", lat); end
    n_tests++; if (da !== 0) begin n_fail++; $display("FAIL dir_done_pulse: done still %0d expected 0", da); end
    n_tests++; if (got_p(0) !== 62) begin n_fail++; $display("FAIL dir_ptch_pterm: got %0d expected 62", got_p(0)); end
    n_tests++; if (got_d(0) !== 441) begin n_fail++; $display("FAIL dir_ptch_dterm: got %0d expected 441", got_d(0)); end
    act_v = '{0, 32767, -1000};
    des_v = '{0, -32768, 0};
    send_sample(lat, da);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL dir2_latency: got %0d expected 4", lat); end
    n_tests++; if (got_p(1) !== 318) begin n_fail++; $display("FAIL dir_roll_pterm: got %0d expected 318", got_p(1)); end
    n_tests++; if (got_d(1) !== 441) begin n_fail++; $display("FAIL dir_roll_dterm: got %0d expected 441", got_d(1)); end
    n_tests++; if (got_p(2) !== -320) begin n_fail++; $display("FAIL dir_yaw_pterm: got %0d expected -320", got_p(2)); end
    n_tests++; if (got_d(2) !== -448) begin n_fail++; $display("FAIL dir_yaw_dterm: got %0d expected -448", got_d(2)); end
    // ptch error falls from 100 to 0 against a zero oldest entry
    n_tests++; if (got_d(0) !== exp_d[0]) begin n_fail++; $display("FAIL dir2_ptch_dterm: got %0d expected %0d", got_d(0), exp_d[0]); end
  endtask

  task automatic test_wrap();
    int lat, da, want;
    apply_reset();
    act_v = '{100, 0, 0};
    des_v = '{0, 0, 0};
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_sample(lat, da);
      want = (i <= DEPTH) ? 441 : 0;
      n_tests++; if (got_d(0) !== want) begin n_fail++; $display("FAIL wrap_dterm vld%0d: got %0d expected %0d", i, got_d(0), want); end
      n_tests++; if (got_p(0) !== 62) begin n_fail++; $display("FAIL wrap_pterm vld%0d: got %0d expected 62", i, got_p(0)); end
    end
  endtask

  task automatic test_random();
    int lat, da;
    logic [15:0] r;
    for (int n = 0; n < 40; n++) begin
      for (int a = 0; a < 3; a++) begin
        if ($urandom_range(0, 1) == 0) begin
          act_v[a] = int'($urandom_range(0, 1200)) - 600;
          des_v[a] = int'($urandom_range(0, 200)) - 100;
        end else begin
          r = 16'($urandom); act_v[a] = int'($signed(r));
          r = 16'($urandom); des_v[a] = int'($signed(r));
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_sample(lat, da);
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rnd_latency #%0d: got %0d expected 4", n, lat); end
      n_tests++; if (da !== 0) begin n_fail++; $display("FAIL rnd_done_pulse #%0d: done %0d expected 0", n, da); end
      for (int a = 0; a < 3; a++) begin
        n_tests++; if (got_p(a) !== exp_p[a]) begin n_fail++; $display("FAIL rnd_pterm #%0d axis %0d: got %0d expected %0d", n, a, got_p(a), exp_p[a]); end
        n_tests++; if (got_d(a) !== exp_d[a]) begin n_fail++; $display("FAIL rnd_dterm #%0d axis %0d: got %0d expected %0d", n, a, got_d(a), exp_d[a]); end
      end
    end
    n_tests++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL rnd_ovr: got %b expected 0", bus.ovr); end
  endtask

  task automatic test_overrun();
    int done_cnt = 0;
    act_v = '{300, -50, 20};
    des_v = '{0, 40, -700};
    @(negedge clk);
    drive_inputs();
    bus.vld = 1'b1;
    model_step();
    @(negedge clk);
    bus.vld = 1'b0;
    @(negedge clk);
    // now in ROLL: a second sample with different attitudes must be ignored
    act_v = '{-3000, 3000, 1};
    des_v = '{5, 6, 7};
    drive_inputs();
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_tests++; if (bus.ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", bus.ovr); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ovr_done_count: got %0d expected 1", done_cnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy_end: got %b expected 0", bus.busy); end
    for (int a = 0; a < 3; a++) begin
      n_tests++; if (got_p(a) !== exp_p[a]) begin n_fail++; $display("FAIL ovr_pterm axis %0d: got %0d expected %0d", a, got_p(a), exp_p[a]); end
      n_tests++; if (got_d(a) !== exp_d[a]) begin n_fail++; $display("FAIL ovr_dterm axis %0d: got %0d expected %0d", a, got_d(a), exp_d[a]); end
    end
`ifdef PD_OVR_CNT_EN
    n_tests++; if (bus.ovr_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_cnt: got %0d expected 1", bus.ovr_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, da;
    act_v = '{250, 250, 250};
    des_v = '{0, 0, 0};
    @(negedge clk);
    drive_inputs();
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL mid_async_ovr: got %b expected 0", bus.ovr); end
    n_tests++; if (got_p(0) !== 0) begin n_fail++; $display("FAIL mid_async_pterm: got %0d expected 0", got_p(0)); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b expected 0", bus.done); end
    act_v = '{100, 0, 0};
    des_v = '{0, 0, 0};
    send_sample(lat, da);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL mid_latency: got %0d expected 4", lat); end
    n_tests++; if (got_d(0) !== 441) begin n_fail++; $display("FAIL mid_ptch_dterm: got %0d expected 441", got_d(0)); end
    n_tests++; if (got_p(0) !== 62) begin n_fail++; $display("FAIL mid_ptch_pterm: got %0d expected 62", got_p(0)); end
    n_tests++; if (got_d(1) !== 0) begin n_fail++; $display("FAIL mid_roll_dterm: got %0d expected 0", got_d(1)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.vld = 1'b0;
    act_v   = '{0, 0, 0};
    des_v   = '{0, 0, 0};
    drive_inputs();
    test_reset();
    test_directed();
    test_wrap();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
